// File: rtl/squat_meter_gen.sv
// Squat depth meter overlay: renders a depth bar and a target line into the VGA stream,
// with frame-synchronous sample updates and a timed HIT celebration state.
module squat_meter_gen #(
  parameter logic [9:0] BAR_X0     = 10'd288,
  parameter logic [9:0] BAR_X1     = 10'd352,
  parameter logic [9:0] TGT_X0     = 10'd256,
  parameter logic [9:0] TGT_X1     = 10'd384,
  parameter logic [5:0] HIT_FRAMES = 6'd32
) (
  input  logic       vgaclk,
  input  logic       reset,
  input  logic [9:0] hcnt,
  input  logic [9:0] vcnt,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       blank_b,
  input  logic       depth_valid,
  input  logic [8:0] depth,
  input  logic [8:0] target,
  output logic       depth_ready,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       blank_o,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);

  typedef enum logic [1:0] {StIdle, StTrack, StHit} state_e;
  typedef enum logic [1:0] {PixBg, PixTgt, PixGreen, PixYellow} pix_e;

  state_e     state_q;
  logic       pend_full_q;
  logic [8:0] pend_depth_q, pend_target_q;
  logic [8:0] act_depth_q, act_target_q;
  logic [8:0] act_depth_d, act_target_d;
  logic [5:0] frame_cnt_q;
  logic [5:0] hit_cnt_q;

  logic       accept;
  logic       frame_tick;
  logic       loaded;
  logic [8:0] depth_clamp, target_clamp;

  assign depth_ready  = ~pend_full_q;
  assign accept       = depth_valid & ~pend_full_q;
  assign frame_tick   = (hcnt == 10'd0) && (vcnt == 10'd480);
  assign depth_clamp  = (depth > 9'd479) ? 9'd479 : depth;
  assign target_clamp = (target > 9'd479) ? 9'd479 : target;
  assign loaded       = frame_tick & (pend_full_q | accept);

  // Active pair only moves on the frame tick; an empty pend lets a coincident sample bypass it.
  always_comb begin
    act_depth_d  = act_depth_q;
    act_target_d = act_target_q;
    if (frame_tick) begin
      if (pend_full_q) begin
        act_depth_d  = pend_depth_q;
        act_target_d = pend_target_q;
      end else if (accept) begin
        act_depth_d  = depth_clamp;
        act_target_d = target_clamp;
      end
    end
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      pend_full_q   <= 1'b0;
      pend_depth_q  <= 9'd0;
      pend_target_q <= 9'd0;
      act_depth_q   <= 9'd0;
      act_target_q  <= 9'd0;
      frame_cnt_q   <= 6'd0;
      hit_cnt_q     <= 6'd0;
    end else begin
      act_depth_q  <= act_depth_d;
      act_target_q <= act_target_d;
      if (frame_tick) begin
        pend_full_q <= 1'b0;
      end else if (accept) begin
        pend_depth_q  <= depth_clamp;
        pend_target_q <= target_clamp;
        pend_full_q   <= 1'b1;
      end
      if (frame_tick) begin
        frame_cnt_q <= frame_cnt_q + 6'd1;
        case (state_q)
          StIdle: begin
            if (loaded) state_q <= StTrack;
          end
          StTrack: begin
            if (act_depth_d >= act_target_d) begin
              state_q   <= StHit;
              hit_cnt_q <= HIT_FRAMES - 6'd1;
            end
          end
          StHit: begin
            if (hit_cnt_q == 6'd0) state_q <= StTrack;
            else                   hit_cnt_q <= hit_cnt_q - 6'd1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Stage 1: pixel classification and timing delay.
  logic [9:0] tgt_row, bar_top;
  logic       in_tgt, in_bar;
  pix_e       pix_d, pix_q;
  logic       hsync_s1_q, vsync_s1_q, blank_s1_q;

  assign tgt_row = 10'd479 - {1'b0, act_target_q};
  assign bar_top = 10'd479 - {1'b0, act_depth_q};
  assign in_tgt  = (vcnt == tgt_row) && (hcnt >= TGT_X0) && (hcnt < TGT_X1);
  assign in_bar  = (hcnt >= BAR_X0) && (hcnt < BAR_X1) && (vcnt >= bar_top);

  always_comb begin
    pix_d = PixBg;
    if (state_q != StIdle) begin
      if (in_tgt) begin
        pix_d = PixTgt;
      end else if (in_bar) begin
        pix_d = (state_q == StHit && frame_cnt_q[2]) ? PixYellow : PixGreen;
      end
    end
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      pix_q      <= PixBg;
      hsync_s1_q <= 1'b1;
      vsync_s1_q <= 1'b1;
      blank_s1_q <= 1'b0;
    end else begin
      pix_q      <= pix_d;
      hsync_s1_q <= hsync;
      vsync_s1_q <= vsync;
      blank_s1_q <= blank_b;
    end
  end

  // Stage 2: colour lookup and output registers.
  logic [11:0] rgb_d, rgb_q;
  logic        hsync_s2_q, vsync_s2_q, blank_s2_q;

  always_comb begin
    rgb_d = 12'h000;
    if (blank_s1_q) begin
      unique case (pix_q)
        PixTgt:    rgb_d = 12'hF00;
        PixGreen:  rgb_d = 12'h0F0;
        PixYellow: rgb_d = 12'hFF0;
        PixBg:     rgb_d = 12'h002;
      endcase
    end
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      rgb_q      <= 12'h000;
      hsync_s2_q <= 1'b1;
      vsync_s2_q <= 1'b1;
      blank_s2_q <= 1'b0;
    end else begin
      rgb_q      <= rgb_d;
      hsync_s2_q <= hsync_s1_q;
      vsync_s2_q <= vsync_s1_q;
      blank_s2_q <= blank_s1_q;
    end
  end

  assign r       = rgb_q[11:8];
  assign g       = rgb_q[7:4];
  assign b       = rgb_q[3:0];
  assign hsync_o = hsync_s2_q;
  assign vsync_o = vsync_s2_q;
  assign blank_o = blank_s2_q;

endmodule

// File: tb/tb_squat_meter_gen.sv
// Directed bench for squat_meter_gen: drives pixel coordinates directly and checks colours.
module tb_squat_meter_gen;

  logic       vgaclk = 1'b0;
  logic       reset;
  logic [9:0] hcnt, vcnt;
  logic       hsync, vsync, blank_b;
  logic       depth_valid;
  logic [8:0] depth, target;
  logic       depth_ready, hsync_o, vsync_o, blank_o;
  logic [3:0] r, g, b;

  int n_checks = 0;
  int n_fail   = 0;

  squat_meter_gen dut (
    .vgaclk      (vgaclk),
    .reset       (reset),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_b     (blank_b),
    .depth_valid (depth_valid),
    .depth       (depth),
    .target      (target),
    .depth_ready (depth_ready),
    .hsync_o     (hsync_o),
    .vsync_o     (vsync_o),
    .blank_o     (blank_o),
    .r           (r),
    .g           (g),
    .b           (b)
  );

  always #5 vgaclk = ~vgaclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] timing_of(input int x, input int y);
    logic hs, vs, bl;
    hs = !(x >= 656 && x < 752);
    vs = !(y >= 490 && y < 492);
    bl = (x < 640) && (y < 480);
    return {hs, vs, bl};
  endfunction

  task automatic drive_xy(input int x, input int y);
    logic [2:0] t;
    t = timing_of(x, y);
    hcnt    = x[9:0];
    vcnt    = y[9:0];
    hsync   = t[2];
    vsync   = t[1];
    blank_b = t[0];
  endtask

  task automatic park();
    drive_xy(700, 500);
  endtask

  task automatic tick();
    @(negedge vgaclk);
    drive_xy(0, 480);
    @(negedge vgaclk);
    park();
  endtask

  task automatic send(input logic [8:0] d, input logic [8:0] t);
    @(negedge vgaclk);
    depth_valid = 1'b1;
    depth       = d;
    target      = t;
    @(negedge vgaclk);
    depth_valid = 1'b0;
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
    @(negedge vgaclk);
    drive_xy(x, y);
    @(posedge vgaclk);
    @(posedge vgaclk);
    #1;
    chk(tag, {20'd0, r, g, b}, {20'd0, exp});
    chk({tag, "_tim"}, {29'd0, hsync_o, vsync_o, blank_o}, {29'd0, timing_of(x, y)});
  endtask

  logic [15:0] hpat = 16'b1110_1011_0010_1101;
  logic [15:0] vpat = 16'b1011_0111_1001_1011;
  logic [15:0] bpat = 16'b0110_1101_0011_1001;
  logic [11:0] exp_rgb;

  initial begin
    reset       = 1'b1;
    depth_valid = 1'b0;
    depth       = 9'd0;
    target      = 9'd0;
    park();
    repeat (3) @(posedge vgaclk);
    #1;
    chk("rst_rgb", {20'd0, r, g, b}, 32'h0);
    chk("rst_tim", {29'd0, hsync_o, vsync_o, blank_o}, 32'b110);
    chk("rst_ready", {31'd0, depth_ready}, 32'd1);
    @(negedge vgaclk);
    reset = 1'b0;

    // Two-cycle timing delay and blank masking, in IDLE on a background pixel.
    hcnt = 10'd300;
    vcnt = 10'd100;
    for (int i = 0; i < 10; i++) begin
      @(negedge vgaclk);
      hsync   = hpat[i[3:0]];
      vsync   = vpat[i[3:0]];
      blank_b = bpat[i[3:0]];
      @(posedge vgaclk);
      #1;
      if (i >= 1) begin
        int j;
        j = i - 1;
        chk("dly_hs", {31'd0, hsync_o}, {31'd0, hpat[j[3:0]]});
        chk("dly_vs", {31'd0, vsync_o}, {31'd0, vpat[j[3:0]]});
        chk("dly_bl", {31'd0, blank_o}, {31'd0, bpat[j[3:0]]});
        exp_rgb = bpat[j[3:0]] ? 12'h002 : 12'h000;
        chk("dly_rgb", {20'd0, r, g, b}, {20'd0, exp_rgb});
      end
    end

    pix("idle_act", 300, 100, 12'h002);
    pix("idle_blk", 700, 500, 12'h000);
    pix("idle_corner", 639, 479, 12'h002);
    pix("idle_hblank", 640, 100, 12'h000);

    tick();  // frame 1, no sample
    pix("idle_after_tick", 300, 479, 12'h002);

    send(9'd100, 9'd200);
    chk("pend_ready0", {31'd0, depth_ready}, 32'd0);
    tick();  // frame 2 -> TRACK
    chk("tick_ready1", {31'd0, depth_ready}, 32'd1);
    pix("bar_top", 300, 379, 12'h0F0);
    pix("bar_bottom", 300, 479, 12'h0F0);
    pix("above_bar", 300, 378, 12'h002);
    pix("bar_left", 288, 400, 12'h0F0);
    pix("bar_right", 351, 400, 12'h0F0);
    pix("bar_out_r", 352, 400, 12'h002);
    pix("tgt_left", 256, 279, 12'hF00);
    pix("tgt_right", 383, 279, 12'hF00);
    pix("tgt_out_l", 255, 279, 12'h002);
    pix("tgt_out_r", 384, 279, 12'h002);

    // Two samples before a tick: the second waits until the pend empties.
    send(9'd50, 9'd60);
    @(negedge vgaclk);
    depth_valid = 1'b1;
    depth       = 9'd400;
    target      = 9'd100;
    @(posedge vgaclk);
    #1;
    chk("second_wait", {31'd0, depth_ready}, 32'd0);
    @(negedge vgaclk);
    drive_xy(0, 480);  // frame 3
    @(negedge vgaclk);
    park();
    @(negedge vgaclk);
    depth_valid = 1'b0;
    chk("second_in_pend", {31'd0, depth_ready}, 32'd0);
    pix("first_bar", 300, 429, 12'h0F0);
    pix("first_above", 300, 428, 12'h002);
    pix("first_tgt", 300, 419, 12'hF00);

    tick();  // frame 4 -> HIT (frame_cnt=4, yellow)
    chk("hit_ready", {31'd0, depth_ready}, 32'd1);
    pix("hit_bar", 300, 79, 12'hFF0);
    pix("hit_above", 300, 78, 12'h002);
    pix("tgt_over_bar", 300, 379, 12'hF00);

    // Clamped sample arrives mid-HIT; HIT must not retrigger and ends after 32 ticks.
    send(9'd500, 9'd300);
    for (int k = 5; k <= 37; k++) begin
      tick();
      if (k == 36) exp_rgb = 12'h0F0;
      else         exp_rgb = ((k & 4) != 0) ? 12'hFF0 : 12'h0F0;
      pix("hit_seq", 300, 200, exp_rgb);
    end
    pix("clamp_row0", 300, 0, 12'hFF0);
    pix("clamp_tgt", 260, 179, 12'hF00);

    // Handshake coinciding with a tick while the pend is empty (frame 38).
    @(negedge vgaclk);
    depth_valid = 1'b1;
    depth       = 9'd20;
    target      = 9'd30;
    drive_xy(0, 480);
    @(negedge vgaclk);
    depth_valid = 1'b0;
    park();
    #1;
    chk("bypass_ready", {31'd0, depth_ready}, 32'd1);
    pix("bypass_bar", 300, 459, 12'hFF0);
    pix("bypass_above", 300, 458, 12'h002);
    pix("bypass_tgt", 300, 449, 12'hF00);

    // Reset mid-frame with a pending sample and HIT in progress.
    send(9'd10, 9'd10);
    pix("pre_rst", 300, 200, 12'h002);
    @(negedge vgaclk);
    reset = 1'b1;
    #1;
    chk("async_rgb", {20'd0, r, g, b}, 32'h0);
    chk("async_tim", {29'd0, hsync_o, vsync_o, blank_o}, 32'b110);
    chk("async_ready", {31'd0, depth_ready}, 32'd1);
    repeat (2) @(negedge vgaclk);
    reset = 1'b0;
    tick();
    pix("post_rst_idle", 300, 479, 12'h002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/squat_meter_gen.md
SQUAT_METER_GEN -- requirements
Module: squat_meter_gen

Interface
REQ-001 The module SHALL have the parameter BAR_X0, default 10'd288, meaning the left column of the bar, inclusive.
REQ-002 The module SHALL have the parameter BAR_X1, default 10'd352, meaning the right column of the bar, exclusive.
REQ-003 The module SHALL have the parameter TGT_X0, default 10'd256, meaning the left column of the target line, inclusive.
REQ-004 The module SHALL have the parameter TGT_X1, default 10'd384, meaning the right column of the target line, exclusive.
REQ-005 The module SHALL have the parameter HIT_FRAMES, default 6'd32, meaning the number of frames the HIT state lasts.
REQ-006 vgaclk  input  1  pixel clock; all state SHALL change on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high.
REQ-008 hcnt  input  10  horizontal pixel count from the timing controller (0..800).
REQ-009 vcnt  input  10  line count from the timing controller (0..525).
REQ-010 hsync, vsync, blank_b  input  1 each  timing controller outputs; syncs are active-low, blank_b is high in the active area.
REQ-011 depth_valid  input  1  producer has a depth sample.
REQ-012 depth  input  9  squat depth in lines.
REQ-013 target  input  9  target depth in lines, sampled together with depth.
REQ-014 depth_ready  output  1  module can accept a sample.
REQ-015 hsync_o, vsync_o, blank_o  output  1 each  timing signals delayed to align with the colour outputs.
REQ-016 r, g, b  output  4 each  pixel colour to the DAC.

Function
REQ-017 A sample SHALL transfer on any rising edge where depth_valid=1 and depth_ready=1; depth_ready SHALL equal ~pend_full, combinationally.
REQ-018 An accepted {depth, target} pair SHALL be written to a one-entry pending register and SHALL set pend_full.
REQ-019 Values above 479 SHALL be clamped to 479 at acceptance.
REQ-020 The frame tick SHALL be the single cycle where hcnt==0 and vcnt==480.
REQ-021 On a frame tick with pend_full=1, the pending pair SHALL be copied to the active pair and pend_full SHALL clear.
REQ-022 If a handshake and a frame tick coincide while pend is empty, the new pair SHALL go directly to the active pair and pend_full SHALL stay 0.
REQ-023 The active pair SHALL change only on frame ticks, so no tearing is allowed mid-frame.
REQ-024 A 6-bit frame counter SHALL increment on every frame tick and wrap from 63 to 0.
REQ-025 The FSM SHALL have three states: IDLE, TRACK and HIT, with all transitions evaluated only on frame ticks, using the active pair after the update.
REQ-026 IDLE SHALL go to TRACK when an active pair was loaded on this tick.
REQ-027 TRACK SHALL go to HIT when active depth >= active target, and SHALL load hit_cnt with HIT_FRAMES-1.
REQ-028 HIT SHALL decrement hit_cnt on each tick and SHALL return to TRACK when hit_cnt==0; a new depth >= target during HIT SHALL NOT retrigger it.
REQ-029 Pixel classification SHALL assign tgt when y==479-target and TGT_X0<=x<TGT_X1.
REQ-030 Pixel classification SHALL assign bar when BAR_X0<=x<BAR_X1 and y>=479-depth.
REQ-031 All comparisons SHALL be unsigned 10-bit.
REQ-032 Colour priority SHALL be tgt, then bar, then background.
REQ-033 A tgt pixel SHALL be red F/0/0.
REQ-034 A bar pixel SHALL be green 0/F/0 in TRACK, and in HIT yellow F/F/0 when frame_cnt[2]=1, otherwise green.
REQ-035 A background pixel SHALL be 0/0/2.
REQ-036 In IDLE, every active pixel SHALL be background.
REQ-037 The pipeline SHALL have exactly 2 cycles of latency: stage 1 registers the classification and the delayed timing, and stage 2 registers r/g/b.
REQ-038 hsync_o, vsync_o and blank_o SHALL equal hsync, vsync and blank_b delayed by 2 cycles.
REQ-039 r, g and b SHALL be 0 whenever the delayed blank is 0.

Reset
REQ-040 While reset=1, r/g/b SHALL be 0, hsync_o=vsync_o=1, blank_o=0, depth_ready=1, pend_full=0, the active pair 0, frame_cnt=0, hit_cnt=0 and the state IDLE.
REQ-041 Reset asserted mid-frame SHALL discard any pending sample and the HIT progress, and outputs SHALL return to their reset values asynchronously.
REQ-042 The first frame tick after reset release with no sample SHALL keep the state IDLE.

Verification
REQ-043 Reset, then run a full frame -> r/g/b=0/0/2 at active pixels, 0 in blanking, and the syncs equal the inputs delayed by 2 cycles.
REQ-044 Send depth=100, target=200, then a frame tick -> TRACK, with green at (300,379..479), black-blue at (300,378), and red at (256..383,279).
REQ-045 Send two samples before a tick -> the second waits with depth_ready=0 until the tick, and the first is displayed.
REQ-046 Send depth=500, target=300 -> clamped to 479, the bar fills rows 0..479, HIT is entered, the bar alternates yellow/green every 4 frames, and the state returns to TRACK after 32 ticks.
REQ-047 Handshake coinciding with a tick while pend is empty -> the sample is active immediately and depth_ready stays 1.
REQ-048 Assert reset during HIT at vcnt=200 -> outputs are 0 immediately, and the state is IDLE after release.
